// File: rtl/cycle_seq_pkg.sv
// Shared types and sizing helpers for the cycle sequencer and its tick divider.
package cycle_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    // Width of the divider count; a single bit is kept even when DIV==1.
    function automatic int div_cnt_w(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Counts enabled clk cycles modulo DIV; due flags the cycle that completes a tick period.
module tick_divider
    import cycle_seq_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic due
);

    localparam int W = div_cnt_w(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] div_cnt_q;
    logic [W-1:0] div_cnt_d;

    assign due = (div_cnt_q == LAST);

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (clr) begin
            div_cnt_d = '0;
        end else if (en) begin
            div_cnt_d = due ? '0 : div_cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/cycle_sequencer.sv
// Turns raw clk edges into a divided tick stream, counts ticks, and flags done at MAX_CYC.
// start/halt are plain levels sampled on posedge; there is no handshake back to the driver.
module cycle_sequencer
    import cycle_seq_pkg::*;
#(
    parameter int          DIV     = 2,
    parameter int          CNT_W   = 32,
    parameter int unsigned MAX_CYC = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             halt,
    output logic             tick,
    output logic [CNT_W-1:0] cyc,
    output logic             done,
    output logic [1:0]       state
);

    if (DIV < 1 || CNT_W < 1 || 64'(MAX_CYC) >= (64'd1 << CNT_W)) begin : g_param_err
        $fatal(1, "cycle_sequencer: DIV must be >= 1 and MAX_CYC must fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_CYC);

    seq_state_e       state_q, state_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic             done_q, done_d;

    logic             due;
    logic             run_go;
    logic             restart;
    logic [CNT_W-1:0] cyc_inc;
    logic             hit_limit;

    // halt wins over a due tick, so the divider only advances while running unhalted.
    assign run_go    = (state_q == RUN) && !halt;
    assign restart   = ((state_q == IDLE) || (state_q == DONE)) && start;
    assign cyc_inc   = cyc_q + CNT_W'(1);
    assign hit_limit = (MAX_CYC != 0) && (cyc_inc == MAX_V);

    tick_divider #(
        .DIV (DIV)
    ) u_tick_divider (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (run_go),
        .clr   (restart),
        .due   (due)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: if (start) state_d = RUN;
            RUN: begin
                if (halt) begin
                    state_d = PAUSE;
                end else if (due && hit_limit) begin
                    state_d = DONE;
                end
            end
            PAUSE:   if (!halt) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tick_d = run_go && due;
        cyc_d  = cyc_q;
        done_d = done_q;
        if (restart) begin
            cyc_d  = '0;
            done_d = 1'b0;
        end else if (tick_d) begin
            cyc_d = cyc_inc;
            if (hit_limit) begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= 1'b0;
            cyc_q  <= '0;
            done_q <= 1'b0;
        end else begin
            tick_q <= tick_d;
            cyc_q  <= cyc_d;
            done_q <= done_d;
        end
    end

    assign tick  = tick_q;
    assign cyc   = cyc_q;
    assign done  = done_q;
    assign state = state_q;

endmodule

// File: doc/cycle_sequencer.md
Name: cycle_sequencer

Overview:
Synthesizable consumer of the free-running testbench/system clock. Converts raw `clk` edges into a gated, divided tick stream, counts the ticks, and raises a terminal `done` flag at a programmable cycle limit. Downstream logic uses `tick` as its clock enable and `done` as its finish request, so cycle-limit logic no longer lives in ad-hoc `always` blocks.

Parameters:
- DIV, 2, clk cycles per tick; legal range ≥1 (DIV=1 gives a tick every cycle).
- CNT_W, 32, width of the tick counter `cyc`.
- MAX_CYC, 10, tick count at which `done` asserts. 0 means never; `cyc` wraps modulo 2^CNT_W.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level sampled at posedge; begins or restarts a run.
- halt  in  1  level; pauses the run while high.
- tick  out  1  registered; one-cycle pulse per DIV running cycles.
- cyc  out  CNT_W  registered; ticks issued since the last start.
- done  out  1  registered level; high once cyc reaches MAX_CYC.
- state  out  2  current FSM state, for debug.

Behaviour:
- Reset:
  - rst_n low forces, immediately and asynchronously: state=IDLE, tick=0, cyc=0, done=0, internal div_cnt=0.
  - This also applies mid-run; there is no partial-state retention.
- div_cnt width is max(1, $clog2(DIV)).
- FSM states: IDLE=0, RUN=1, PAUSE=2, DONE=3.
- tick defaults to 0 every edge unless set below, so it is always a single-cycle pulse.
- IDLE:
  - start=1 → RUN; div_cnt<=0; cyc<=0.
  - halt is ignored in IDLE.
- RUN, halt=1:
  - → PAUSE. div_cnt and cyc hold; no tick.
  - halt has priority over a due tick.
- RUN, halt=0, div_cnt≠DIV-1: div_cnt<=div_cnt+1.
- RUN, halt=0, div_cnt==DIV-1:
  - div_cnt<=0, tick<=1, cyc<=cyc+1.
  - If MAX_CYC≠0 and cyc+1==MAX_CYC, also state<=DONE and done<=1 on the same edge.
  - In that case tick and done rise together.
- PAUSE:
  - halt=0 → RUN, with div_cnt unchanged.
  - A tick that halt suppressed fires on the first RUN edge with div_cnt==DIV-1.
- DONE:
  - cyc holds, done stays high, no ticks.
  - start=1 → RUN; cyc<=0; done<=0; div_cnt<=0.
- start in RUN or PAUSE is ignored; there is no restart mid-run.
- Simultaneous start and halt in IDLE or DONE: enter RUN. halt takes effect on the next edge.
- Latency:
  - First tick is high in the cycle after the DIV-th posedge following the start-sampling edge.
  - Tick k (1-based) occurs k·DIV edges after the start edge, with no halts.
- Wrap: with MAX_CYC=0, cyc rolls from 2^CNT_W-1 to 0 with no flag.
- Elaboration check: fatal if DIV<1, or if MAX_CYC ≥ 2^CNT_W.

Decomposition:
- Package `cycle_seq_pkg`:
  - typedef enum logic [1:0] seq_state_e {IDLE, RUN, PAUSE, DONE}.
  - localparam helper for the div_cnt width.
- One natural sub-module, `tick_divider`:
  - Inputs: clk, rst_n, en, clr.
  - Output: due (div_cnt==DIV-1).
  - Holds div_cnt.
  - The FSM and cyc/done logic stay in the top.

Test Plan:
1. DIV=2, MAX_CYC=10; reset released, start pulsed at edge 0, halt=0 → tick high after edges 2,4,…,20; cyc counts 1..10; done=1 and state=DONE after edge 20; no further ticks for 10 cycles.
2. DIV=3; halt asserted at the edge where div_cnt==2 and held 4 cycles → no tick during PAUSE; tick fires on the first RUN edge after halt drops; cyc is not double-incremented.
3. DONE state, start=1 → cyc=0 and done=0 next cycle; ten fresh ticks at the same spacing as scenario 1.
4. DIV=2; rst_n pulsed low mid-run at cyc=5 → all outputs 0 without waiting for a clk edge; after release, state=IDLE until start.
5. DIV=1, MAX_CYC=0, CNT_W=4 → tick high every cycle; cyc wraps 15→0; done never asserts.
6. start and halt both high in IDLE → state=RUN after that edge, PAUSE after the next edge; no tick issued.
